// File: rtl/kyber_pkg.sv
// Shared constants, mode encodings and FSM state encoding for the Kyber polynomial memory.
package kyber_pkg;

    localparam int COEF_W = 12;
    localparam int N_COEF = 8;
    localparam int DATA_W = COEF_W * N_COEF;
    localparam int ADDR_W = 8;

    localparam logic [1:0] MODE_NTT    = 2'd0;
    localparam logic [1:0] MODE_INTT   = 2'd1;
    localparam logic [1:0] MODE_MULT   = 2'd2;
    localparam logic [1:0] MODE_ADDSUB = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/kyber_poly_mem_ram.sv
// poly_ram: DEPTH x DATA_W RAM, one write port, one synchronous read port.
// A read colliding with a write to the same address returns the old word.
module poly_ram #(
    parameter int DATA_W = 96,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  widx;
    logic [IDX_W-1:0]  ridx;

    // Power-of-two depth: dropping high address bits gives the modulo wrap.
    assign widx = IDX_W'(waddr);
    assign ridx = IDX_W'(raddr);

    always_ff @(posedge clk) begin
        if (we)
            mem[widx] <= wdata;
    end

    // Only the output register is reset; array contents survive reset.
    always_ff @(posedge clk) begin
        if (rst)
            rdata <= '0;
        else
            rdata <= mem[ridx];
    end

endmodule

// File: rtl/kyber_poly_mem.sv
// Polynomial memory responder and command sequencer for the NTT core.
// Optional run timeout: define KYBER_MEM_TIMEOUT_EN.
module kyber_poly_mem #(
    parameter int DATA_W  = kyber_pkg::DATA_W,
    parameter int ADDR_W  = kyber_pkg::ADDR_W,
    parameter int DEPTH   = 256,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_we,
    input  logic              host_re,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ready,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mode,
    input  logic              cmd_add_sub,
    input  logic [ADDR_W-1:0] cmd_off_a,
    input  logic [ADDR_W-1:0] cmd_off_b,
    input  logic [ADDR_W-1:0] cmd_off_w,
    output logic              core_start,
    output logic [1:0]        core_mode,
    output logic              core_add_or_sub,
    output logic [ADDR_W-1:0] core_off_a,
    output logic [ADDR_W-1:0] core_off_b,
    output logic [ADDR_W-1:0] core_off_w,
    input  logic [ADDR_W-1:0] core_r_addr,
    output logic [DATA_W-1:0] core_r_data,
    input  logic [ADDR_W-1:0] core_w_addr,
    input  logic [DATA_W-1:0] core_w_data,
    input  logic              core_w_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    import kyber_pkg::*;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("kyber_poly_mem: TIMEOUT must be at least 1");
    end

    state_t            state_q, state_d;
    logic              seen_write;
    logic              cmd_acc;
    logic              tmo_hit;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr, ram_raddr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;

    // Ready is withheld while rst is asserted so nothing is accepted in a reset cycle.
    assign host_ready = (state_q == ST_IDLE) && !rst;
    assign cmd_ready  = (state_q == ST_IDLE) && !rst;
    assign cmd_acc    = cmd_valid && cmd_ready;
    assign busy       = (state_q != ST_IDLE);
    assign core_start = (state_q == ST_START);
    assign done       = (state_q == ST_DONE);

`ifdef KYBER_MEM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;
    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cmd_acc) state_d = ST_START;
            ST_START: state_d = ST_RUN;
            ST_RUN:   if ((seen_write && !core_w_en) || tmo_hit) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            seen_write      <= 1'b0;
            host_rvalid     <= 1'b0;
            core_mode       <= '0;
            core_add_or_sub <= 1'b0;
            core_off_a      <= '0;
            core_off_b      <= '0;
            core_off_w      <= '0;
        end else begin
            state_q     <= state_d;
            host_rvalid <= host_re && !host_we && host_ready;
            if (state_q == ST_START)
                seen_write <= 1'b0;
            else if (state_q == ST_RUN && core_w_en)
                seen_write <= 1'b1;
            if (cmd_acc) begin
                core_mode       <= cmd_mode;
                core_add_or_sub <= cmd_add_sub;
                core_off_a      <= cmd_off_a;
                core_off_b      <= cmd_off_b;
                core_off_w      <= cmd_off_w;
            end
        end
    end

`ifdef KYBER_MEM_TIMEOUT_EN
    // err is sticky across DONE/IDLE and only clears when a new command is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (state_q == ST_START)
                tmo_cnt <= '0;
            else if (state_q == ST_RUN)
                tmo_cnt <= tmo_cnt + 1'b1;
            if (cmd_acc)
                err <= 1'b0;
            else if (state_q == ST_RUN && tmo_hit && !(seen_write && !core_w_en))
                err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

    // Core owns both RAM ports while busy; host owns them in IDLE.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = host_addr;
        ram_wdata = host_wdata;
        ram_raddr = host_addr;
        if (busy) begin
            ram_we    = core_w_en && !rst;
            ram_waddr = core_w_addr;
            ram_wdata = core_w_data;
            ram_raddr = core_r_addr;
        end else begin
            ram_we    = host_we && host_ready;
        end
    end

    poly_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .raddr(ram_raddr),
        .rdata(ram_rdata)
    );

    assign core_r_data = ram_rdata;
    assign host_rdata  = ram_rdata;

endmodule
